// File: rtl/map_checkpoint_buffer_pkg.sv
// Shared rename types: map snapshot layout and checkpoint tag width.
// Imported by the checkpoint buffer and the map table.
package map_checkpoint_buffer_pkg;

    localparam int unsigned NUM_CKPT  = 4;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned TAG_W     = $clog2(NUM_CKPT);

    typedef logic [PREG_W-1:0]         preg_t;
    typedef preg_t [0:ARCH_REGS-1]     map_t;
    typedef logic [TAG_W-1:0]          ckpt_tag_t;
    typedef logic [TAG_W:0]            ckpt_cnt_t;

    // Architectural register i maps to physical register i out of reset.
    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) begin
            m[i] = preg_t'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/map_checkpoint_buffer.sv
// Branch checkpoint buffer: snapshots the speculative map per branch in program
// order and replays the snapshot to the map table on a mispredict.
module map_checkpoint_buffer
    import map_checkpoint_buffer_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      branch_valid,
    input  map_t      map_in,
    output ckpt_tag_t ckpt_tag,
    output logic      ckpt_full,
    output logic      ckpt_empty,
    input  logic      resolve_valid,
    input  ckpt_tag_t resolve_tag,
    input  logic      resolve_mispredict,
    output logic      mispredict,
    output map_t      re_map
);

    map_t                snap_q [NUM_CKPT];
    map_t                snap_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] live_q, live_d;
    logic [NUM_CKPT-1:0] done_q, done_d;
    ckpt_tag_t           head_q, head_d;
    ckpt_tag_t           tail_q, tail_d;
    ckpt_cnt_t           count_q, count_d;

    logic      restore;
    logic      correct;
    logic      alloc;
    logic      free;
    ckpt_tag_t restore_age;

    always_comb begin
        restore     = resolve_valid && resolve_mispredict && live_q[resolve_tag];
        correct     = resolve_valid && !resolve_mispredict && live_q[resolve_tag];
        alloc       = branch_valid && !ckpt_full && !restore;
        free        = live_q[head_q] && done_q[head_q] && !restore;
        // Age of the mispredicted slot relative to the oldest live checkpoint.
        restore_age = resolve_tag - head_q;
    end

    always_comb begin
        live_d  = live_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int k = 0; k < NUM_CKPT; k++) begin
            snap_d[k] = snap_q[k];
        end

        if (restore) begin
            // Squash the mispredicted slot and everything younger than it.
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (ckpt_tag_t'(ckpt_tag_t'(k) - head_q) >= restore_age) begin
                    live_d[k] = 1'b0;
                    done_d[k] = 1'b0;
                end
            end
            tail_d  = resolve_tag;
            count_d = ckpt_cnt_t'(restore_age);
        end else begin
            if (correct) begin
                done_d[resolve_tag] = 1'b1;
            end
            if (free) begin
                live_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + ckpt_tag_t'(1);
            end
            if (alloc) begin
                snap_d[tail_q] = map_in;
                live_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + ckpt_tag_t'(1);
            end
            if (alloc && !free) begin
                count_d = count_q + ckpt_cnt_t'(1);
            end else if (free && !alloc) begin
                count_d = count_q - ckpt_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                snap_q[k] <= identity_map();
            end
        end else begin
            live_q  <= live_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int k = 0; k < NUM_CKPT; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    // Restore path is combinational so the map table recovers on this edge.
    always_comb begin
        ckpt_tag   = tail_q;
        ckpt_full  = (count_q == ckpt_cnt_t'(NUM_CKPT));
        ckpt_empty = (count_q == '0);
        mispredict = restore;
        re_map     = snap_q[resolve_tag];
    end

endmodule

// File: tb/tb_map_checkpoint_buffer.sv
// Directed bench for map_checkpoint_buffer with a program-order queue model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_map_checkpoint_buffer;
    import map_checkpoint_buffer_pkg::*;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      branch_valid = 1'b0;
    map_t      map_in;
    ckpt_tag_t ckpt_tag;
    logic      ckpt_full;
    logic      ckpt_empty;
    logic      resolve_valid = 1'b0;
    ckpt_tag_t resolve_tag = '0;
    logic      resolve_mispredict = 1'b0;
    logic      mispredict;
    map_t      re_map;

    int vectors = 0;
    int miscompares = 0;

    map_checkpoint_buffer dut (
        .clk                (clk),
        .reset              (reset),
        .branch_valid       (branch_valid),
        .map_in             (map_in),
        .ckpt_tag           (ckpt_tag),
        .ckpt_full          (ckpt_full),
        .ckpt_empty         (ckpt_empty),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .mispredict         (mispredict),
        .re_map             (re_map)
    );

    always #5 clk = ~clk;

    // Model: live checkpoints as a queue, oldest first; snapshot memory by tag.
    typedef struct {
        ckpt_tag_t tag;
        logic      done;
    } ent_t;

    ent_t      q[$];
    map_t      mem [NUM_CKPT];
    ckpt_tag_t m_tail;

    function automatic map_t ident();
        map_t m;
        for (int i = 0; i < ARCH_REGS; i++) m[i] = preg_t'(i);
        return m;
    endfunction

    function automatic int find(ckpt_tag_t t);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic model_init();
        q.delete();
        m_tail = '0;
        for (int k = 0; k < NUM_CKPT; k++) mem[k] = ident();
    endtask

    task automatic model_step();
        int   pos;
        logic fr;
        logic al;
        if (reset) begin
            model_init();
            return;
        end
        pos = resolve_valid ? find(resolve_tag) : -1;
        if (pos >= 0 && resolve_mispredict) begin
            while (q.size() > pos) void'(q.pop_back());
            m_tail = resolve_tag;
        end else begin
            fr = (q.size() > 0) && q[0].done;
            al = branch_valid && (q.size() < NUM_CKPT);
            if (pos >= 0) q[pos].done = 1'b1;
            if (fr) void'(q.pop_front());
            if (al) begin
                q.push_back('{tag: m_tail, done: 1'b0});
                mem[m_tail] = map_in;
                m_tail = m_tail + ckpt_tag_t'(1);
            end
        end
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        logic exp_mp;
        forever begin
            @(negedge clk);
            exp_mp = !reset && resolve_valid && resolve_mispredict && (find(resolve_tag) >= 0);
            chk("model ckpt_tag", int'(ckpt_tag), int'(m_tail));
            chk("model ckpt_full", int'(ckpt_full), int'(q.size() == NUM_CKPT));
            chk("model ckpt_empty", int'(ckpt_empty), int'(q.size() == 0));
            chk("model mispredict", int'(mispredict), int'(exp_mp));
            vectors++;
            if (re_map !== mem[resolve_tag]) begin
                miscompares++;
                $display("FAIL model re_map: got %h expected %h", re_map, mem[resolve_tag]);
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
        branch_valid       = 1'b0;
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic alloc_br(input int m1);
        map_in          = ident();
        map_in[1]       = preg_t'(m1);
        branch_valid    = 1'b1;
    endtask

    task automatic resolve(input int t, input logic mp);
        resolve_valid      = 1'b1;
        resolve_tag        = ckpt_tag_t'(t);
        resolve_mispredict = mp;
    endtask

    initial begin
        map_in = ident();
        repeat (2) @(posedge clk);
        #1;
        chk("reset empty", int'(ckpt_empty), 1);
        chk("reset full", int'(ckpt_full), 0);
        chk("reset tag", int'(ckpt_tag), 0);
        chk("reset mispredict", int'(mispredict), 0);
        chk("reset re_map[5]", int'(re_map[5]), 5);
        reset = 1'b0;

        // Fill, then a dropped fifth branch.
        for (int i = 0; i < 4; i++) begin
            alloc_br(40 + i);
            #1 chk("fill tag", int'(ckpt_tag), i);
            go();
        end
        #1 chk("fill full", int'(ckpt_full), 1);
        alloc_br(99);
        go();
        #1 chk("drop tag", int'(ckpt_tag), 0);
        chk("drop full", int'(ckpt_full), 1);

        // Out-of-order correct resolves: free waits for the head.
        resolve(1, 1'b0);
        go();
        resolve(0, 1'b0);
        go();
        #1 chk("no early free", int'(ckpt_full), 1);
        go();
        #1 chk("free head0", int'(ckpt_full), 0);
        go();
        resolve(0, 1'b1);
        #1 chk("freed tag mp", int'(mispredict), 0);
        go();
        resolve(2, 1'b1);
        alloc_br(77);
        #1 chk("head mp", int'(mispredict), 1);
        chk("head re_map[1]", int'(re_map[1]), 42);
        go();
        #1 chk("head mp empty", int'(ckpt_empty), 1);
        chk("head mp tag", int'(ckpt_tag), 2);

        // Reset while live: no mispredict escapes.
        alloc_br(50);
        go();
        reset = 1'b1;
        resolve(2, 1'b1);
        #1 chk("reset mid mp", int'(mispredict), 0);
        chk("reset mid empty", int'(ckpt_empty), 1);
        go();
        reset = 1'b0;

        // Mispredict in the middle of three live checkpoints.
        for (int i = 0; i < 3; i++) begin
            alloc_br(40 + i);
            go();
        end
        resolve(1, 1'b1);
        #1 chk("mid mp", int'(mispredict), 1);
        chk("mid re_map[1]", int'(re_map[1]), 41);
        go();
        #1 chk("mid tail", int'(ckpt_tag), 1);
        chk("mid empty", int'(ckpt_empty), 0);
        for (int i = 0; i < 3; i++) begin
            alloc_br(60 + i);
            go();
        end
        #1 chk("mid refill full", int'(ckpt_full), 1);

        // Wrap around with sequential allocate/resolve/free.
        reset = 1'b1;
        go();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alloc_br(10 + i);
            #1 chk("wrap tag", int'(ckpt_tag), i % 4);
            go();
            resolve(i % 4, 1'b0);
            go();
            go();
            #1 chk("wrap empty", int'(ckpt_empty), 1);
        end
        resolve(1, 1'b1);
        #1 chk("stale mp", int'(mispredict), 0);
        go();
        #1 chk("stale tag", int'(ckpt_tag), 2);
        chk("stale empty", int'(ckpt_empty), 1);
        go();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
